// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port data RAM between instruction fetch and load/store
// Sub-word stores become a two-cycle read-modify-write so the RAM needs no byte enables.

module mem_port_arbiter #(
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [31:0]       ls_addr,
    input  logic [31:0]       ls_wdata,
    input  logic [1:0]        ls_type,
    input  logic              ls_unsig,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [31:0]       ls_rdata,
    output logic              ls_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic {IDLE, RMW} state_e;

    state_e              state_q, state_d;
    logic                last_if_q, last_if_d;
    logic                if_rv_q;
    logic                ls_rv_q;
    logic                ls_err_q;
    logic                ls_load_q;
    logic [1:0]          ls_off_q;
    logic [1:0]          ls_type_q;
    logic                ls_unsig_q;
    logic [15:0]         ls_wdata_q;
    logic [RAM_AW-1:0]   ls_waddr_q;

    logic                grant_ok;
    logic                pick_ls;
    logic [1:0]          ls_off;
    logic                ls_word;
    logic                ls_mis;
    logic                ls_sub_st;
    logic [31:0]         merged;
    logic [31:0]         shifted;
    logic [31:0]         ext;
    logic                unused_bits;

    assign unused_bits = ^{if_addr[31:RAM_AW+2], if_addr[1:0], ls_addr[31:RAM_AW+2]};

    // Grants are gated by rst_n so every output is 0 while reset is held.
    assign grant_ok  = rst_n && (state_q == IDLE);
    assign pick_ls   = ls_req && (!if_req || last_if_q);
    assign if_gnt    = grant_ok && if_req && !pick_ls;
    assign ls_gnt    = grant_ok && pick_ls;

    assign ls_off    = ls_addr[1:0];
    assign ls_word   = ls_type[1];
    assign ls_mis    = ((ls_type == 2'b01) && ls_off[0]) || (ls_word && (ls_off != 2'b00));
    assign ls_sub_st = ls_we && !ls_word && !ls_mis;

    always_comb begin
        merged = ram_rdata;
        if (!ls_type_q[0]) begin
            case (ls_off_q)
                2'd0:    merged[7:0]   = ls_wdata_q[7:0];
                2'd1:    merged[15:8]  = ls_wdata_q[7:0];
                2'd2:    merged[23:16] = ls_wdata_q[7:0];
                default: merged[31:24] = ls_wdata_q[7:0];
            endcase
        end else if (ls_off_q[1]) begin
            merged[31:16] = ls_wdata_q;
        end else begin
            merged[15:0] = ls_wdata_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_if_d = last_if_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state_q == RMW) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = ls_waddr_q;
            ram_wdata = merged;
            state_d   = IDLE;
        end else if (if_gnt) begin
            ram_en    = 1'b1;
            ram_addr  = if_addr[RAM_AW+1:2];
            last_if_d = 1'b1;
        end else if (ls_gnt) begin
            last_if_d = 1'b0;
            ram_addr  = ls_addr[RAM_AW+1:2];
            // Misaligned accesses never touch the RAM; sub-word stores read first.
            if (!ls_mis) begin
                ram_en = 1'b1;
                if (ls_we && ls_word) begin
                    ram_we    = 1'b1;
                    ram_wdata = ls_wdata;
                end
                if (ls_sub_st) begin
                    state_d = RMW;
                end
            end
        end
    end

    always_comb begin
        shifted = ram_rdata >> {ls_off_q, 3'b000};
        if (ls_type_q[1]) begin
            ext = shifted;
        end else if (ls_type_q[0]) begin
            ext = {{16{shifted[15] & !ls_unsig_q}}, shifted[15:0]};
        end else begin
            ext = {{24{shifted[7] & !ls_unsig_q}}, shifted[7:0]};
        end
    end

    assign if_rvalid = if_rv_q;
    assign if_rdata  = if_rv_q ? ram_rdata : 32'h0;
    assign ls_rvalid = ls_rv_q;
    assign ls_err    = ls_err_q;
    assign ls_rdata  = (ls_rv_q && ls_load_q && !ls_err_q) ? ext : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_if_q  <= 1'b1;
            if_rv_q    <= 1'b0;
            ls_rv_q    <= 1'b0;
            ls_err_q   <= 1'b0;
            ls_load_q  <= 1'b0;
            ls_off_q   <= 2'b00;
            ls_type_q  <= 2'b00;
            ls_unsig_q <= 1'b0;
            ls_wdata_q <= 16'h0;
            ls_waddr_q <= '0;
        end else begin
            state_q   <= state_d;
            last_if_q <= last_if_d;
            if_rv_q   <= if_gnt;
            ls_rv_q   <= ls_gnt;
            ls_err_q  <= ls_gnt && ls_mis;
            if (ls_gnt) begin
                ls_load_q  <= !ls_we;
                ls_off_q   <= ls_off;
                ls_type_q  <= ls_type;
                ls_unsig_q <= ls_unsig;
                ls_wdata_q <= ls_wdata[15:0];
                ls_waddr_q <= ls_addr[RAM_AW+1:2];
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a word-array memory model
// The golden memory takes each store's effect at grant time; responses are predicted from it.

module tb_mem_port_arbiter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_gnt, if_rvalid;
    logic [31:0]   if_addr, if_rdata;
    logic          ls_req, ls_we, ls_unsig, ls_gnt, ls_rvalid, ls_err;
    logic [31:0]   ls_addr, ls_wdata, ls_rdata;
    logic [1:0]    ls_type;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.RAM_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_type(ls_type),
        .ls_unsig(ls_unsig), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    logic [31:0] ram_mem [0:1023];
    logic [31:0] gold    [0:1023];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] v;
            v = $urandom;
            gold[i] = v;
            ram_mem[i] <= v;
        end
        ram_rdata <= 32'h0;
    end

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic misal(input logic [1:0] t, input logic [1:0] off);
        return ((t == 2'b01) && off[0]) || (t[1] && (off != 2'b00));
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] t, input logic u);
        logic [31:0] s;
        int sh;
        sh = 8 * int'(off);
        s = w >> sh;
        if (t[1]) return w;
        if (t == 2'b00) begin
            s = s & 32'hFF;
            if (!u && s[7]) s = s | 32'hFFFF_FF00;
        end else begin
            s = s & 32'hFFFF;
            if (!u && s[15]) s = s | 32'hFFFF_0000;
        end
        return s;
    endfunction

    function automatic logic [31:0] store_val(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] t, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (t[1]) return wd;
        sh = 8 * int'(off);
        mask = ((t == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    logic        pend_if = 1'b0, pend_ls = 1'b0, pend_ls_err = 1'b0;
    logic [31:0] pend_if_addr = 32'h0, pend_ls_data = 32'h0;
    logic        s_if_gnt = 1'b0, s_ls_gnt = 1'b0, s_ls_rv = 1'b0, s_ls_err = 1'b0;
    logic        s_ram_en = 1'b0, s_ram_we = 1'b0;
    logic [31:0] s_ls_rdata = 32'h0, s_ram_wdata = 32'h0;
    logic        rand_if = 1'b0;

    task automatic observe();
        check("if_rvalid", 32'(if_rvalid), 32'(pend_if));
        if (pend_if) check("if_rdata", if_rdata, gold[pend_if_addr[11:2]]);
        check("ls_rvalid", 32'(ls_rvalid), 32'(pend_ls));
        if (pend_ls) begin
            check("ls_rdata", ls_rdata, pend_ls_data);
            check("ls_err", 32'(ls_err), 32'(pend_ls_err));
        end
        check("rvalid_excl", 32'(if_rvalid & ls_rvalid), 32'h0);
        check("gnt_excl", 32'(if_gnt & ls_gnt), 32'h0);
        pend_if      = if_gnt;
        pend_if_addr = if_addr;
        pend_ls      = ls_gnt;
        if (ls_gnt) begin
            pend_ls_err  = misal(ls_type, ls_addr[1:0]);
            pend_ls_data = (ls_we || pend_ls_err) ? 32'h0 :
                           load_val(gold[ls_addr[11:2]], ls_addr[1:0], ls_type, ls_unsig);
            if (ls_we && !pend_ls_err)
                gold[ls_addr[11:2]] = store_val(gold[ls_addr[11:2]], ls_addr[1:0], ls_type, ls_wdata);
        end
        s_if_gnt = if_gnt; s_ls_gnt = ls_gnt; s_ls_rv = ls_rvalid; s_ls_err = ls_err;
        s_ls_rdata = ls_rdata; s_ram_en = ram_en; s_ram_we = ram_we; s_ram_wdata = ram_wdata;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        if (rand_if && (!if_req || s_if_gnt)) begin
            if_req  = 1'($urandom_range(0, 1));
            if_addr = 32'h100 + 32'($urandom_range(0, 15)) * 4;
        end
    endtask

    task automatic sample();
        #2;
        observe();
    endtask

    task automatic ls_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] t, input logic u,
                         output logic [31:0] rd, output logic err, output int lat,
                         output logic g_en, output logic p_we, output logic [31:0] p_wd,
                         output logic p_gnt);
        int n;
        next_cycle();
        ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd; ls_type = t; ls_unsig = u;
        sample();
        n = 0;
        while (!s_ls_gnt && n < 20) begin
            next_cycle();
            sample();
            n++;
        end
        if (!s_ls_gnt) check("ls_gnt_timeout", 32'h0, 32'h1);
        g_en = s_ram_en;
        next_cycle();
        ls_req = 1'b0; ls_we = 1'($urandom); ls_addr = $urandom; ls_wdata = $urandom;
        ls_type = 2'($urandom); ls_unsig = 1'($urandom);
        sample();
        p_we = s_ram_we; p_wd = s_ram_wdata; p_gnt = s_if_gnt | s_ls_gnt;
        lat = 1;
        while (!s_ls_rv && lat < 20) begin
            next_cycle();
            sample();
            lat++;
        end
        rd = s_ls_rdata;
        err = s_ls_err;
    endtask

    initial begin
        logic [31:0] rd, pw, saved;
        logic        er, ge, pwe, pg;
        int          lat;

        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_type = 2'b10; ls_unsig = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_ctrl", 32'({if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err, ram_en, ram_we}), 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_ls_rdata", ls_rdata, 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        if_req = 1'b0; ls_req = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        sample();

        // Both sides held: LS first because last_grant starts at IF.
        next_cycle();
        if_req = 1'b1; if_addr = 32'h104;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100; ls_type = 2'b10;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next_cycle();
            sample();
            check("alt_ls_gnt", 32'(s_ls_gnt), 32'((i % 2) == 0));
            check("alt_if_gnt", 32'(s_if_gnt), 32'((i % 2) == 1));
        end
        next_cycle();
        if_req = 1'b0; ls_req = 1'b0;
        sample();

        ls_op(1'b1, 32'h40, 32'h1122_3344, 2'b10, 1'b0, rd, er, lat, ge, pwe, pw, pg);
        check("sw_lat", lat, 1);
        ls_op(1'b0, 32'h43, 32'h0, 2'b00, 1'b0, rd, er, lat, ge, pwe, pw, pg);
        check("lb_43", rd, 32'h0000_0011);
        ls_op(1'b0, 32'h42, 32'h0, 2'b01, 1'b0, rd, er, lat, ge, pwe, pw, pg);
        check("lh_42", rd, 32'h0000_1122);
        ls_op(1'b0, 32'h40, 32'h0, 2'b00, 1'b1, rd, er, lat, ge, pwe, pw, pg);
        check("lbu_40", rd, 32'h0000_0044);

        ls_op(1'b1, 32'h40, 32'h0000_80FF, 2'b10, 1'b0, rd, er, lat, ge, pwe, pw, pg);
        ls_op(1'b1, 32'h41, 32'hFFFF_FFAB, 2'b00, 1'b0, rd, er, lat, ge, pwe, pw, pg);
        check("sb_read_en", 32'(ge), 32'h1);
        check("sb_rmw_we", 32'(pwe), 32'h1);
        check("sb_rmw_wdata", pw, 32'h0000_ABFF);
        check("sb_rmw_nognt", 32'(pg), 32'h0);
        check("sb_lat", lat, 1);
        ls_op(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, rd, er, lat, ge, pwe, pw, pg);
        check("lw_after_sb", rd, 32'h0000_ABFF);
        ls_op(1'b0, 32'h40, 32'h0, 2'b01, 1'b0, rd, er, lat, ge, pwe, pw, pg);
        check("lh_40", rd, 32'hFFFF_ABFF);
        ls_op(1'b0, 32'h40, 32'h0, 2'b01, 1'b1, rd, er, lat, ge, pwe, pw, pg);
        check("lhu_40", rd, 32'h0000_ABFF);

        ls_op(1'b0, 32'h43, 32'h0, 2'b01, 1'b0, rd, er, lat, ge, pwe, pw, pg);
        check("mis_lh_en", 32'(ge), 32'h0);
        check("mis_lh_err", 32'(er), 32'h1);
        check("mis_lh_rdata", rd, 32'h0);
        ls_op(1'b0, 32'h42, 32'h0, 2'b10, 1'b0, rd, er, lat, ge, pwe, pw, pg);
        check("mis_lw_en", 32'(ge), 32'h0);
        check("mis_lw_err", 32'(er), 32'h1);
        check("mis_lw_rdata", rd, 32'h0);

        // Reset lands in the RMW write cycle of a halfword store.
        ls_op(1'b1, 32'h80, 32'h1234_5678, 2'b10, 1'b0, rd, er, lat, ge, pwe, pw, pg);
        saved = gold[32'h80 >> 2];
        next_cycle();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h82; ls_wdata = 32'h0000_BEEF; ls_type = 2'b01; ls_unsig = 1'b0;
        sample();
        check("sh_gnt", 32'(s_ls_gnt), 32'h1);
        @(negedge clk);
        ls_req = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rmw_rst_we", 32'(ram_we), 32'h0);
        check("rmw_rst_ctrl", 32'({if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err, ram_en}), 32'h0);
        check("rmw_rst_wdata", ram_wdata, 32'h0);
        pend_ls = 1'b0; pend_if = 1'b0; s_ls_rv = 1'b0;
        gold[32'h80 >> 2] = saved;
        next_cycle();
        rst_n = 1'b1;
        sample();
        ls_op(1'b0, 32'h80, 32'h0, 2'b10, 1'b0, rd, er, lat, ge, pwe, pw, pg);
        check("rmw_abort_lw", rd, 32'h1234_5678);

        for (int i = 0; i < 8; i++) begin
            next_cycle();
            if_req = 1'b1; if_addr = 32'(i * 4);
            sample();
            check("b2b_if_gnt", 32'(s_if_gnt), 32'h1);
            check("b2b_if_rv", 32'(if_rvalid), 32'(i > 0));
        end
        next_cycle();
        if_req = 1'b0;
        sample();
        check("b2b_last_rv", 32'(if_rvalid), 32'h1);

        rand_if = 1'b1;
        for (int k = 0; k < 60; k++) begin
            ls_op(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 63)), $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd, er, lat, ge, pwe, pw, pg);
            check("rand_lat", lat, 1);
        end
        rand_if = 1'b0;
        next_cycle();
        if_req = 1'b0;
        sample();
        next_cycle();
        sample();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
